// File: rtl/stopw_mux.sv
// stopw_mux: multi-decade BCD stopwatch with a multiplexed 7-segment display.
//
// Ports
//   Clk        system clock; all state changes happen on its rising edge
//   RES        asynchronous reset, active high
//   StartStop  a rising edge toggles run/stop
//   Lap        a rising edge toggles display freeze (only when STOPW_LAP_EN is defined)
//   Clr        level; zeroes the time, prescaler, Ovf and freeze while stopped
//   AN         one-hot digit enable, bit 0 = least significant decade
//   Y          segments a..g on Y[6:0], decimal point on Y[7] (always 0)
//   Running    high while the stopwatch is counting
//   Ovf        sticky flag, set when the count wraps from all nines
//
// Configuration macro: STOPW_LAP_EN builds the lap freeze and hold register.
// Without it Lap is ignored and the display always shows the live count.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_STOPPED | prescaler and decades hold; Clr is honoured
// ST_RUNNING | prescaler runs, decades advance on each tick
module stopw_mux #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic              Clk,
  input  logic              RES,
  input  logic              StartStop,
  input  logic              Lap,
  input  logic              Clr,
  output logic [DIGITS-1:0] AN,
  output logic [7:0]        Y,
  output logic              Running,
  output logic              Ovf
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_armed, r_ss_d;
  logic                   w_ss_edge, w_tick, w_clr;
  logic [PW-1:0]          r_pre, w_pre_nxt;
  logic [DIGITS-1:0][3:0] r_dec, w_dec_nxt, w_disp;
  logic                   r_ovf, w_ovf_nxt;
  logic [SW-1:0]          r_scan;
  logic [IW-1:0]          r_idx;
  logic [3:0]             w_digit;
  logic [6:0]             w_seg;

  // r_armed is low only for the first cycle after reset. It keeps an input
  // that was already high during reset from being seen as a rising edge
  // while the edge-detect registers still hold their reset value of 0.
  always_ff @(posedge Clk or posedge RES) begin
    if (RES) begin
      r_armed <= 1'b0;
      r_ss_d  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_ss_d  <= StartStop;
    end
  end

  assign w_ss_edge = StartStop & ~r_ss_d & r_armed;

  always_ff @(posedge Clk or posedge RES) begin
    if (RES) r_state <= ST_STOPPED;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    Running     = 1'b0;
    w_clr       = 1'b0;
    w_tick      = 1'b0;
    case (r_state)
      ST_STOPPED: begin
        w_clr = Clr;
        if (w_ss_edge) w_state_nxt = ST_RUNNING;
      end
      ST_RUNNING: begin
        Running = 1'b1;
        w_tick  = (r_pre == PRE_LAST);
        if (w_ss_edge) w_state_nxt = ST_STOPPED;
      end
      default: w_state_nxt = ST_STOPPED;
    endcase
  end

  // Ripple carry through the decades: a decade advances only when every
  // lower decade is at 9. A carry out of the top decade is the overflow.
  always_comb begin
    logic carry;
    w_dec_nxt = r_dec;
    w_pre_nxt = r_pre;
    w_ovf_nxt = r_ovf;
    carry     = w_tick;
    if (r_state == ST_RUNNING)
      w_pre_nxt = (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (r_dec[k] == 4'd9) begin
          w_dec_nxt[k] = 4'd0;
        end else begin
          w_dec_nxt[k] = r_dec[k] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
    if (carry) w_ovf_nxt = 1'b1;
    if (w_clr) begin
      w_dec_nxt = '0;
      w_pre_nxt = '0;
      w_ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge RES) begin
    if (RES) begin
      r_pre <= '0;
      r_dec <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_pre <= w_pre_nxt;
      r_dec <= w_dec_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign Ovf = r_ovf;

`ifdef STOPW_LAP_EN
  logic                   r_lap_d, r_frz;
  logic                   w_lap_edge;
  logic [DIGITS-1:0][3:0] r_hold;

  assign w_lap_edge = Lap & ~r_lap_d & r_armed;

  // The hold register captures the count as it stands before this edge's
  // increment. A clear while stopped takes priority over a Lap edge.
  always_ff @(posedge Clk or posedge RES) begin
    if (RES) begin
      r_lap_d <= 1'b0;
      r_frz   <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_lap_d <= Lap;
      if (w_clr) begin
        r_frz <= 1'b0;
      end else if (w_lap_edge) begin
        r_frz <= ~r_frz;
        if (!r_frz) r_hold <= r_dec;
      end
    end
  end

  assign w_disp = r_frz ? r_hold : r_dec;
`else
  logic w_unused_lap;
  assign w_unused_lap = Lap;
  assign w_disp       = r_dec;
`endif

  always_ff @(posedge Clk or posedge RES) begin
    if (RES) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  assign w_digit = w_disp[r_idx];

  always_comb begin
    AN        = '0;
    AN[r_idx] = 1'b1;
  end

  always_comb begin
    w_seg = 7'h00;
    case (w_digit)
      4'd0: w_seg = 7'h3F;
      4'd1: w_seg = 7'h06;
      4'd2: w_seg = 7'h5B;
      4'd3: w_seg = 7'h4F;
      4'd4: w_seg = 7'h66;
      4'd5: w_seg = 7'h6D;
      4'd6: w_seg = 7'h7D;
      4'd7: w_seg = 7'h07;
      4'd8: w_seg = 7'h7F;
      4'd9: w_seg = 7'h6F;
      default: w_seg = 7'h00;
    endcase
  end

  assign Y = {1'b0, w_seg};

endmodule
